// File: rtl/branch_compare_pipe_pkg.sv
// Shared types for the pipelined branch comparator.
// Branch function codes, result bundle and sizing limits.
package branch_compare_pipe_pkg;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_BLT  = 3'b100,
    CMP_BGE  = 3'b101,
    CMP_BLTU = 3'b110,
    CMP_BGEU = 3'b111
  } comparator_func_code;

  localparam int BRANCH_CMP_MAX_LATENCY = 4;
  localparam int BRANCH_CMP_MIN_XLEN    = 8;
  localparam int BRANCH_CMP_MAX_TAG_W   = 16;

  typedef struct packed {
    logic                            taken;
    logic                            mispredict;
    logic                            illegal;
    logic [BRANCH_CMP_MAX_TAG_W-1:0] tag;
  } branch_cmp_res_t;

endpackage

// File: rtl/branch_compare_pipe_stage.sv
// One valid/ready register slice of the branch compare pipe.
// Flush clears only the valid bit; payload is left as-is.
module branch_compare_stage
  import branch_compare_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  branch_cmp_res_t i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output branch_cmp_res_t o_data
);

  logic            r_valid;
  branch_cmp_res_t r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Occupancy: load when the slot frees up, drop everything on flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
    end
  end

  // Payload: capture on every transfer into this slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (o_ready && i_valid) begin
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/branch_compare_pipe.sv
// Pipelined RV32I branch comparator with tag and mispredict check.
// Optional perf counters: define BRANCH_COMPARE_PERF_EN.
module branch_compare_pipe
  import branch_compare_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  comparator_func_code in_func,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                in_pred_taken,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_taken,
  output logic                out_mispredict,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag,
  output logic [31:0]         perf_resolved,
  output logic [31:0]         perf_mispredict
);

  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_raw;
  logic            w_legal;
  branch_cmp_res_t w_res;
  branch_cmp_res_t w_out;
  logic            w_unused_tag;

  assign w_eq   = (in_a == in_b);
  assign w_lt_s = ($signed(in_a) < $signed(in_b));
  assign w_lt_u = (in_a < in_b);

  // Resolve the condition and build the stage-1 payload.
  always_comb begin
    w_raw   = 1'b0;
    w_legal = 1'b1;
    w_res   = '0;
    case (in_func)
      CMP_BEQ:  w_raw = w_eq;
      CMP_BNE:  w_raw = !w_eq;
      CMP_BLT:  w_raw = w_lt_s;
      CMP_BGE:  w_raw = !w_lt_s;
      CMP_BLTU: w_raw = w_lt_u;
      CMP_BGEU: w_raw = !w_lt_u;
      default:  w_legal = 1'b0;
    endcase
    w_res.illegal          = !w_legal;
    w_res.taken            = w_legal && w_raw;
    w_res.mispredict       = w_legal && (w_raw ^ in_pred_taken);
    w_res.tag[TAG_W-1:0]   = in_tag;
  end

  genvar gi;
  for (gi = 0; gi < LATENCY; gi++) begin : g_stg
    logic            w_iv;
    logic            w_ir;
    logic            w_ov;
    logic            w_dr;
    branch_cmp_res_t w_id;
    branch_cmp_res_t w_od;

    if (gi == 0) begin : g_head
      assign w_iv = in_valid;
      assign w_id = w_res;
    end else begin : g_link
      assign w_iv = g_stg[gi-1].w_ov;
      assign w_id = g_stg[gi-1].w_od;
    end

    if (gi == LATENCY - 1) begin : g_tail
      assign w_dr = out_ready;
    end else begin : g_mid
      assign w_dr = g_stg[gi+1].w_ir;
    end

    branch_compare_stage u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_valid (w_iv),
      .o_ready (w_ir),
      .i_data  (w_id),
      .o_valid (w_ov),
      .i_ready (w_dr),
      .o_data  (w_od)
    );
  end

  assign in_ready       = g_stg[0].w_ir;
  assign out_valid      = g_stg[LATENCY-1].w_ov;
  assign w_out          = g_stg[LATENCY-1].w_od;
  assign out_taken      = w_out.taken;
  assign out_mispredict = w_out.mispredict;
  assign out_illegal    = w_out.illegal;
  assign out_tag        = w_out.tag[TAG_W-1:0];
  assign w_unused_tag   = ^w_out.tag;

`ifdef BRANCH_COMPARE_PERF_EN
  logic [31:0] r_perf_resolved;
  logic [31:0] r_perf_mispredict;

  // Count legal results as they retire; flush never touches these.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_resolved   <= '0;
      r_perf_mispredict <= '0;
    end else if (out_valid && out_ready && !w_out.illegal) begin
      r_perf_resolved <= r_perf_resolved + 32'd1;
      if (w_out.mispredict) begin
        r_perf_mispredict <= r_perf_mispredict + 32'd1;
      end
    end
  end

  assign perf_resolved   = r_perf_resolved;
  assign perf_mispredict = r_perf_mispredict;
`else
  assign perf_resolved   = '0;
  assign perf_mispredict = '0;
`endif

endmodule
